oppm_encoder: RTL and testbench

- Transmit-side OPPM (offset pulse-position modulation) encoder. The player FSMs drive it through start_ENC/data_ENC and watch avail_ENC.
- Accepts one N_PKT-bit packet and emits it as a single-wire pulse train on the optical driver: fixed preamble, then one pulse per N_MOD-bit symbol, then a guard gap.
- Its counterpart is the OPPM decoder that feeds data_DEC/avail_DEC.

---
 rtl/oppm_pkg.sv | 26 ++
 rtl/oppm_slot_timer.sv | 49 ++++
 rtl/oppm_encoder.sv | 129 ++++++++++++
 tb/tb_oppm_encoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oppm_pkg.sv
// Shared OPPM definitions: default link constants, FSM state type and frame-geometry helpers.
// The decoder imports the same package so both ends agree on the framing.
`timescale 1ns/1ps
package oppm_pkg;

  localparam int DEF_N_PKT       = 48;
  localparam int DEF_N_MOD       = 2;
  localparam int DEF_SLOT_CYCLES = 4;
  localparam int DEF_PRE_PULSES  = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    GUARD
  } state_e;

  function automatic int n_sym(input int n_pkt, input int n_mod);
    return n_pkt / n_mod;
  endfunction

  function automatic int frame_len(input int n_mod, input int slot_cycles);
    return (1 << n_mod) * slot_cycles;
  endfunction

endpackage

// File: rtl/oppm_slot_timer.sv
// Slot timer: counts cycles within a slot and slots within a frame, flagging the last
// cycle of each slot and of each frame. A synchronous clear restarts at slot 0, cycle 0.
`timescale 1ns/1ps
module oppm_slot_timer #(
  parameter int N_MOD       = 2,
  parameter int SLOT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [N_MOD-1:0] slot_idx,
  output logic             slot_end,
  output logic             frame_end
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [SW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [N_MOD-1:0] slot_idx_q, slot_idx_d;

  always_comb begin
    slot_end   = (slot_cnt_q == SW'(SLOT_CYCLES - 1));
    frame_end  = slot_end && (&slot_idx_q);
    slot_cnt_d = slot_cnt_q + SW'(1);
    slot_idx_d = slot_idx_q;
    // Slot index wraps naturally at frame end, which is exactly the frame boundary.
    if (slot_end) begin
      slot_cnt_d = '0;
      slot_idx_d = slot_idx_q + N_MOD'(1);
    end
    if (clr) begin
      slot_cnt_d = '0;
      slot_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      slot_idx_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      slot_idx_q <= slot_idx_d;
    end
  end

  assign slot_idx = slot_idx_q;

endmodule

// File: rtl/oppm_encoder.sv
// OPPM transmit encoder: latches a packet, then emits preamble pulses, one pulse per
// N_MOD-bit symbol (slot position = symbol value, MSB first) and a silent guard frame.
`timescale 1ns/1ps
module oppm_encoder
  import oppm_pkg::*;
#(
  parameter int N_PKT       = DEF_N_PKT,
  parameter int N_MOD       = DEF_N_MOD,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int PRE_PULSES  = DEF_PRE_PULSES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_PKT-1:0] data,
  output logic             avail,
  output logic             pulse,
  output logic             done
);

  localparam int N_SYM   = n_sym(N_PKT, N_MOD);
  localparam int CNT_MAX = (N_SYM > PRE_PULSES) ? N_SYM : PRE_PULSES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (N_PKT % N_MOD != 0) begin : g_bad_mod
    $error("oppm_encoder: N_PKT must be divisible by N_MOD");
  end
  if (SLOT_CYCLES < 1) begin : g_bad_slot
    $error("oppm_encoder: SLOT_CYCLES must be at least 1");
  end
  if (PRE_PULSES < 1) begin : g_bad_pre
    $error("oppm_encoder: PRE_PULSES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [N_PKT-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tmr_clr;
  logic [N_MOD-1:0] slot_idx;
  logic             slot_end, frame_end;

  oppm_slot_timer #(
    .N_MOD      (N_MOD),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .slot_idx (slot_idx),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tmr_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (start) begin
          shreg_d = data;
          cnt_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        // A preamble period is two slots; odd slot index marks its second half.
        if (slot_end && slot_idx[0]) begin
          if (cnt_q == CNT_W'(PRE_PULSES - 1)) begin
            cnt_d   = '0;
            tmr_clr = 1'b1;
            state_d = DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DATA: begin
        if (frame_end) begin
          shreg_d = shreg_q << N_MOD;
          if (cnt_q == CNT_W'(N_SYM - 1)) begin
            cnt_d   = '0;
            state_d = GUARD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      GUARD: begin
        if (frame_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    avail = (state_q == IDLE);
    done  = done_q;
    unique case (state_q)
      PRE:     pulse = ~slot_idx[0];
      DATA:    pulse = (slot_idx == shreg_q[N_PKT-1 -: N_MOD]);
      default: pulse = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_oppm_encoder.sv
// Self-checking bench: two encoders (defaults and N_MOD=3/SLOT_CYCLES=2) share stimulus and
// are compared every cycle against a timeline model of the pulse train.
`timescale 1ns/1ps
module tb_oppm_encoder;

  localparam int NP    = 48;
  localparam int A_MOD = 2;
  localparam int A_SLT = 4;
  localparam int B_MOD = 3;
  localparam int B_SLT = 2;
  localparam int PREP  = 4;
  localparam int A_BUSY = PREP * 2 * A_SLT + (NP / A_MOD) * (1 << A_MOD) * A_SLT + (1 << A_MOD) * A_SLT;
  localparam int B_BUSY = PREP * 2 * B_SLT + (NP / B_MOD) * (1 << B_MOD) * B_SLT + (1 << B_MOD) * B_SLT;

  typedef struct {
    bit          busy;
    int          t;
    logic [NP-1:0] pkt;
    bit          done;
  } model_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NP-1:0] data;
  logic          avail_a, pulse_a, done_a;
  logic          avail_b, pulse_b, done_b;

  int     checks   = 0;
  int     failures = 0;
  bit     cmp_en   = 1'b0;
  int     cur      = 0;
  model_t ma = '{busy: 1'b0, t: 0, pkt: '0, done: 1'b0};
  model_t mb = '{busy: 1'b0, t: 0, pkt: '0, done: 1'b0};

  always #5 clk = ~clk;

  oppm_encoder u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (data),
    .avail(avail_a),
    .pulse(pulse_a),
    .done (done_a)
  );

  oppm_encoder #(
    .N_PKT      (NP),
    .N_MOD      (B_MOD),
    .SLOT_CYCLES(B_SLT),
    .PRE_PULSES (PREP)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .data (data),
    .avail(avail_b),
    .pulse(pulse_b),
    .done (done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  // Expected pulse at cycle t of a busy period, straight from the framing rules.
  function automatic bit exp_pulse(input logic [NP-1:0] pkt, input int t, input int nmod,
                                   input int slot);
    int pre_len, frame, nsym, d, sym, off, v;
    pre_len = PREP * 2 * slot;
    frame   = (1 << nmod) * slot;
    nsym    = NP / nmod;
    if (t < pre_len) return (t % (2 * slot)) < slot;
    d = t - pre_len;
    if (d >= nsym * frame) return 1'b0;
    sym = d / frame;
    off = d % frame;
    v   = int'(pkt >> (NP - nmod * (sym + 1))) & ((1 << nmod) - 1);
    return (off / slot) == v;
  endfunction

  function automatic model_t step(input model_t m, input logic rst, input logic st,
                                  input logic [NP-1:0] d, input int busy_len);
    model_t n;
    n = m;
    if (!rst) begin
      n.busy = 1'b0; n.t = 0; n.done = 1'b0;
    end else if (!m.busy) begin
      n.done = 1'b0;
      if (st) begin
        n.busy = 1'b1; n.t = 0; n.pkt = d;
      end
    end else if (m.t == busy_len - 1) begin
      n.busy = 1'b0; n.done = 1'b1;
    end else begin
      n.t = m.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, rst_n, start, data, A_BUSY);
    mb <= step(mb, rst_n, start, data, B_BUSY);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_avail", avail_a, !ma.busy);
      check("a_done",  done_a,  ma.done);
      check("a_pulse", pulse_a, ma.busy ? exp_pulse(ma.pkt, ma.t, A_MOD, A_SLT) : 1'b0);
      check("b_avail", avail_b, !mb.busy);
      check("b_done",  done_b,  mb.done);
      check("b_pulse", pulse_b, mb.busy ? exp_pulse(mb.pkt, mb.t, B_MOD, B_SLT) : 1'b0);
    end
  end

  task automatic run_to(input int c);
    while (cur < c) begin
      @(posedge clk);
      cur++;
    end
    #1;
  endtask

  // Drive start for cycle 0 of a new scenario; the packet is accepted at the next edge.
  task automatic begin_pkt(input logic [NP-1:0] d);
    @(posedge clk);
    #1;
    cur   = 0;
    start = 1'b1;
    data  = d;
    run_to(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while ((ma.busy || mb.busy) && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_idle_timeout", {ma.busy, mb.busy}, 2'b00);
  endtask

  initial begin
    int cnt_a, cnt_b;

    // Pin the reference model to hand-derived values.
    check("pin_pre_first",  exp_pulse(48'h0, 0, A_MOD, A_SLT), 1'b1);
    check("pin_pre_gap",    exp_pulse(48'h0, 4, A_MOD, A_SLT), 1'b0);
    check("pin_c_sym0_on",  exp_pulse(48'hC00000000001, 44, A_MOD, A_SLT), 1'b1);
    check("pin_c_sym0_off", exp_pulse(48'hC00000000001, 43, A_MOD, A_SLT), 1'b0);
    check("pin_c_last_on",  exp_pulse(48'hC00000000001, 404, A_MOD, A_SLT), 1'b1);
    check("pin_b_ones_on",  exp_pulse(48'hFFFFFFFFFFFF, 30, B_MOD, B_SLT), 1'b1);
    check("pin_b_ones_off", exp_pulse(48'hFFFFFFFFFFFF, 32, B_MOD, B_SLT), 1'b0);

    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with start low.
    repeat (20) @(posedge clk);
    #1;
    check("idle_avail", avail_a, 1'b1);
    check("idle_pulse", pulse_a, 1'b0);

    // All-zero packet: preamble then slot-0 pulses; count high cycles over the busy time.
    cnt_a = 0;
    cnt_b = 0;
    begin_pkt(48'h0);
    check("zero_c1_pulse", pulse_a, 1'b1);
    check("zero_c1_avail", avail_a, 1'b0);
    for (int c = 1; c <= 433; c++) begin
      run_to(c);
      if (c <= 432) cnt_a += int'(pulse_a);
      if (c <= 288) cnt_b += int'(pulse_b);
      case (c)
        5:   check("zero_c5_pulse", pulse_a, 1'b0);
        33:  check("zero_c33_pulse", pulse_a, 1'b1);
        37:  check("zero_c37_pulse", pulse_a, 1'b0);
        289: check("zero_b_done", done_b, 1'b1);
        401: check("zero_c401_pulse", pulse_a, 1'b1);
        417: check("zero_c417_pulse", pulse_a, 1'b0);
        432: check("zero_c432_avail", avail_a, 1'b0);
        433: begin
          check("zero_c433_done", done_a, 1'b1);
          check("zero_c433_avail", avail_a, 1'b1);
        end
        default: ;
      endcase
    end
    check("zero_a_pulse_count", cnt_a, 112);
    check("zero_b_pulse_count", cnt_b, 40);
    wait_idle(1000);

    // First symbol 3, last symbol 1.
    begin_pkt(48'hC00000000001);
    run_to(44);  check("c_c44_pulse", pulse_a, 1'b0);
    run_to(45);  check("c_c45_pulse", pulse_a, 1'b1);
    run_to(48);  check("c_c48_pulse", pulse_a, 1'b1);
    run_to(49);  check("c_c49_pulse", pulse_a, 1'b1);
    run_to(53);  check("c_c53_pulse", pulse_a, 1'b0);
    run_to(404); check("c_c404_pulse", pulse_a, 1'b0);
    run_to(405); check("c_c405_pulse", pulse_a, 1'b1);
    run_to(409); check("c_c409_pulse", pulse_a, 1'b0);
    wait_idle(1000);

    // start held high and data scrambled every cycle after acceptance.
    @(posedge clk);
    #1;
    cur   = 0;
    start = 1'b1;
    data  = {$urandom, $urandom};
    for (int c = 1; c <= 440; c++) begin
      run_to(c);
      data = {$urandom, $urandom};
      if (c == 433) check("hold_c433_done", done_a, 1'b1);
      if (c == 434) begin
        check("hold_c434_pulse", pulse_a, 1'b1);
        check("hold_c434_avail", avail_a, 1'b0);
      end
    end
    start = 1'b0;
    wait_idle(1000);

    // Reset mid-packet, then a fresh packet.
    begin_pkt({$urandom, $urandom});
    run_to(100);
    rst_n = 1'b0;
    run_to(101);
    rst_n = 1'b1;
    check("rst_c101_pulse", pulse_a, 1'b0);
    check("rst_c101_avail", avail_a, 1'b1);
    check("rst_c101_done",  done_a,  1'b0);
    check("rst_c101_b_avail", avail_b, 1'b1);
    run_to(102);
    start = 1'b1;
    data  = {$urandom, $urandom};
    run_to(103);
    start = 1'b0;
    check("rst_fresh_pulse", pulse_a, 1'b1);
    wait_idle(1000);

    // All-ones packet on the N_MOD=3 instance: pulse in the last slot of every frame.
    begin_pkt(48'hFFFFFFFFFFFF);
    run_to(30);  check("ones_b_c30", pulse_b, 1'b0);
    run_to(31);  check("ones_b_c31", pulse_b, 1'b1);
    run_to(32);  check("ones_b_c32", pulse_b, 1'b1);
    run_to(33);  check("ones_b_c33", pulse_b, 1'b0);
    run_to(272); check("ones_b_c272", pulse_b, 1'b1);
    run_to(288); check("ones_b_c288_avail", avail_b, 1'b0);
    run_to(289); check("ones_b_c289_done", done_b, 1'b1);
    wait_idle(1000);

    // Random packets with stray start requests while busy.
    for (int p = 0; p < 8; p++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      begin_pkt({$urandom, $urandom});
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        start = ($urandom_range(0, 3) == 0);
        data  = {$urandom, $urandom};
      end
      start = 1'b0;
      wait_idle(1000);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
